fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Shares one combinational floating_point_multiplier instance among NUM_REQ requesters.
- Uses round-robin arbitration, a valid/ready handshake per requester and one registered result slot.
- Each result returns with its requester ID and the multiplier's underflow/overflow/invalid flags.
- Sits between scalar compute lanes and the single FP multiplier; the multiplier itself is reused unmodified.

Parameters:
- EXPONENT_WIDTH, 8, exponent bits of the float format
- MANTISSA_WIDTH, 23, mantissa bits of the float format
- NUM_REQ, 4, number of requesters (2..16)
- ID_WIDTH, $clog2(NUM_REQ), width of the requester ID (localparam)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*FW  packed operand A; FW = EXPONENT_WIDTH+MANTISSA_WIDTH+1; requester i at [i*FW +: FW]
- req_b  in  NUM_REQ*FW  packed operand B, same packing
- rsp_valid  out  1  result slot occupied
- rsp_ready  in  1  consumer accepts result
- rsp_out  out  FW  product
- rsp_id  out  ID_WIDTH  index of the requester that issued the product
- rsp_underflow  out  1  multiplier underflow_flag for this result
- rsp_overflow  out  1  multiplier overflow_flag for this result
- rsp_invalid  out  1  multiplier invalid_operation_flag for this result

Behaviour:
- Reset, asynchronous on rst_n low:
  - rsp_valid=0, rsp_out=0, rsp_id=0, all rsp flags=0.
  - Round-robin pointer=0; sticky flags=0.
  - req_ready is combinational and is 0 while in reset.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - When slot_free, grant the first requester with req_valid=1, searching from the pointer upward with wrap-around (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - req_ready[g]=1 for the granted index only; req_ready is all-zero when the slot is not free or no request is valid.
  - req_ready never depends on req_valid of other lanes beyond the priority scan.
- Issue: the granted req_a/req_b are muxed into the multiplier. On the clock edge where req_valid[g] && req_ready[g]:
  - capture out/flags into the rsp registers.
  - set rsp_id=g and rsp_valid=1.
  - set pointer=(g+1) mod NUM_REQ.
- Latency: 1 cycle from accept to rsp_valid. Throughput is 1 result/cycle when rsp_ready is held high.
- Output hold: while rsp_valid && !rsp_ready, all rsp_* outputs are stable and no new request is accepted.
- Simultaneous drain and accept (rsp_valid && rsp_ready with a grant) in the same cycle: the slot is overwritten with the new result and rsp_valid stays 1.
- Drain without a new grant: rsp_valid goes to 0; the data registers keep their old values.
- No valid requests: the pointer does not move.
- Fairness: with all lanes requesting continuously, grants cycle 0,1,...,NUM_REQ-1,0. No lane waits more than NUM_REQ-1 grants.
- Requesters must hold req_valid and operands until accepted. Dropping req_valid before acceptance is allowed; that request is lost and the arbiter is not affected.
- Reset mid-operation: any held result is discarded with no response; the pointer returns to 0.

Optional Feature:
- Macro: FP_MUL_ARB_STICKY_FLAGS_EN.
- Defined:
  - Adds ports sticky_clear (in, 1) and sticky_flags (out, 3, {invalid, overflow, underflow}).
  - sticky_flags ORs in the flags of every accepted result.
  - sticky_clear=1 zeroes sticky_flags on the next edge. If sticky_clear coincides with an accept, the clear wins and that cycle's flags are dropped.
  - Reset value of sticky_flags is 0.
- Undefined: these ports and the sticky register do not exist; per-result flags are unchanged.

Decomposition:
- Shared package fp_pkg:
  - float width function FW(EXPONENT_WIDTH, MANTISSA_WIDTH).
  - flag-vector typedef {invalid, overflow, underflow}.
  - constants QNAN/INF bit patterns for the test benches.
- Natural sub-module: rr_arbiter (NUM_REQ) — request vector plus pointer in, one-hot grant and grant index out; purely combinational.
- Top level instantiates rr_arbiter and floating_point_multiplier and holds the pointer, rsp registers and optional sticky register.

Test Plan:
- Single request: lane 2 sends a=0x40400000, b=0x40800000 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_out=0x41400000, rsp_id=2, flags 0/0/0.
- All 4 lanes valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1; each lane's product is correct; req_ready is one-hot every cycle.
- Backpressure: rsp_ready=0 for 3 cycles after one accept -> rsp_* is stable, req_ready=0 throughout. Raising rsp_ready accepts the next lane in the same cycle.
- Flags: lane 1 sends 0x7F800000*0x40400000 -> rsp_out=0x7F800000 with overflow=1. Lane 3 sends 0xFFA00000*0x40800000 -> rsp_out=0xFFC00000 with invalid=1. Lane 0 sends 0x00000001*0x00000001 -> rsp_out=0 with underflow=1.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately, asynchronously. After release, lanes 3 and 0 valid -> the first grant goes to lane 0.
- With FP_MUL_ARB_STICKY_FLAGS_EN: overflow result then underflow result -> sticky_flags=3'b011. Pulse sticky_clear -> sticky_flags=0.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: float width helper, flag vector type and reference bit patterns shared by the arbiter and its bench
package fp_pkg;
  function automatic int fw(input int exponent_width, input int mantissa_width);
    return exponent_width + mantissa_width + 1;
  endfunction
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp_flags_t;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;
endpackage

// File: rtl/fp_mul_arbiter_if.sv
// fp_mul_arbiter_if: requester operand handshakes plus the single result channel
interface fp_mul_arbiter_if #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int NUM_REQ = 4
);
  localparam int FW = fp_pkg::fw(EXPONENT_WIDTH, MANTISSA_WIDTH);
  localparam int ID_WIDTH = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*FW-1:0] req_a;
  logic [NUM_REQ*FW-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [FW-1:0] rsp_out;
  logic [ID_WIDTH-1:0] rsp_id;
  logic rsp_underflow;
  logic rsp_overflow;
  logic rsp_invalid;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_id, rsp_underflow, rsp_overflow, rsp_invalid
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_id, rsp_underflow, rsp_overflow, rsp_invalid
  );
endinterface

// File: rtl/floating_point_multiplier.sv
// floating_point_multiplier: combinational multiply, round-to-nearest-even, results below the normal range flush to zero
module floating_point_multiplier #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic underflow_flag,
  output logic overflow_flag,
  output logic invalid_operation_flag
);
  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int PW = 2 * MW + 2;
  logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, nan, rnd;
  logic [PW-1:0] fa, fb, p, pn;
  logic [EW+MW-1:0] sum;
  int sh, e;
  assign s = a[EW+MW] ^ b[EW+MW];
  assign a_nan = &a[EW+MW-1:MW] && |a[MW-1:0];
  assign b_nan = &b[EW+MW-1:MW] && |b[MW-1:0];
  assign a_inf = &a[EW+MW-1:MW] && !(|a[MW-1:0]);
  assign b_inf = &b[EW+MW-1:MW] && !(|b[MW-1:0]);
  assign a_zero = !(|a[EW+MW-1:0]);
  assign b_zero = !(|b[EW+MW-1:0]);
  assign nan = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
  assign invalid_operation_flag = (a_nan && !a[MW-1]) || (b_nan && !b[MW-1]) || (a_inf && b_zero) || (a_zero && b_inf);
  // Subnormal inputs are normalised by shifting the product until its top bit is set
  always_comb begin
    fa = PW'({|a[EW+MW-1:MW], a[MW-1:0]});
    fb = PW'({|b[EW+MW-1:MW], b[MW-1:0]});
    p = fa * fb;
    pn = p;
    sh = 0;
    for (int i = 0; i < PW; i++) if (!pn[PW-1]) begin
      pn = pn << 1;
      sh = sh + 1;
    end
    e = 1 - sh + (|a[EW+MW-1:MW] ? int'(a[EW+MW-1:MW]) : 1) + (|b[EW+MW-1:MW] ? int'(b[EW+MW-1:MW]) : 1) - BIAS;
    rnd = pn[MW] && (|pn[MW-1:0] || pn[MW+1]);
    sum = {e[EW-1:0], pn[PW-2:MW+1]} + (EW+MW)'(rnd);
    out = {s, {(EW+MW){1'b0}}};
    underflow_flag = 1'b0;
    overflow_flag = 1'b0;
    if (nan) out = {s, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    else if (a_inf || b_inf) begin
      out = {s, {EW{1'b1}}, {MW{1'b0}}};
      overflow_flag = 1'b1;
    end else if (a_zero || b_zero) out = {s, {(EW+MW){1'b0}}};
    else if (e <= 0) underflow_flag = 1'b1;
    else if (e >= (1 << EW) - 1 || &sum[EW+MW-1:MW]) begin
      out = {s, {EW{1'b1}}, {MW{1'b0}}};
      overflow_flag = 1'b1;
    end else out = {s, sum};
  end
endmodule

// File: rtl/fp_mul_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic any
);
  int k;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        gnt[k] = 1'b1;
        idx = k[IW-1:0];
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one FP multiplier behind a single registered result slot
// FP_MUL_ARB_STICKY_FLAGS_EN adds sticky_clear/sticky_flags accumulating the flags of every accepted result
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int NUM_REQ = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
  input  logic sticky_clear,
  output fp_flags_t sticky_flags,
`endif
  fp_mul_arbiter_if.slave bus
);
  localparam int FW = fw(EXPONENT_WIDTH, MANTISSA_WIDTH);
  localparam int ID_WIDTH = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] gnt;
  logic [ID_WIDTH-1:0] idx, ptr_d, ptr_q, rsp_id_d, rsp_id_q;
  logic any, slot_free, accept, rsp_valid_d, rsp_valid_q;
  logic [FW-1:0] mul_a, mul_b, mul_out, rsp_out_d, rsp_out_q;
  fp_flags_t mul_flags, flags_d, flags_q;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(bus.req_valid),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  floating_point_multiplier #(.EXPONENT_WIDTH(EXPONENT_WIDTH), .MANTISSA_WIDTH(MANTISSA_WIDTH)) u_mul (
    .a(mul_a),
    .b(mul_b),
    .out(mul_out),
    .underflow_flag(mul_flags.underflow),
    .overflow_flag(mul_flags.overflow),
    .invalid_operation_flag(mul_flags.invalid)
  );
  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  assign accept = rst_n && slot_free && any;
  assign bus.req_ready = accept ? gnt : '0;
  assign mul_a = bus.req_a[idx*FW +: FW];
  assign mul_b = bus.req_b[idx*FW +: FW];
  always_comb begin
    rsp_valid_d = accept || (rsp_valid_q && !bus.rsp_ready);
    rsp_out_d = accept ? mul_out : rsp_out_q;
    rsp_id_d = accept ? idx : rsp_id_q;
    flags_d = accept ? mul_flags : flags_q;
    ptr_d = !accept ? ptr_q : (idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_out_q <= '0;
      rsp_id_q <= '0;
      flags_q <= '0;
      ptr_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q <= rsp_out_d;
      rsp_id_q <= rsp_id_d;
      flags_q <= flags_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out = rsp_out_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_underflow = flags_q.underflow;
  assign bus.rsp_overflow = flags_q.overflow;
  assign bus.rsp_invalid = flags_q.invalid;
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
  fp_flags_t sticky_d, sticky_q;
  // A clear in the same cycle as an accept drops that result's flags
  always_comb sticky_d = sticky_clear ? '0 : accept ? sticky_q | mul_flags : sticky_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else sticky_q <= sticky_d;
  end
  assign sticky_flags = sticky_q;
`endif
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed vectors against a queue/table model of the arbiter plus hand-computed literal checks
module tb_fp_mul_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
  logic sticky_clear;
  logic [2:0] sticky_flags;
`endif
  int vecs = 0;
  int errs = 0;
  fp_mul_arbiter_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .NUM_REQ(4)) bus ();
  fp_mul_arbiter #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .NUM_REQ(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
    .sticky_clear(sticky_clear),
    .sticky_flags(sticky_flags),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  localparam logic [31:0] TV_A [9] = '{32'h40400000, 32'h40000000, 32'h3FC00000, 32'hBF800000, 32'h00000000,
                                       32'h3F000000, fp_pkg::INF, 32'hFFA00000, 32'h00000001};
  localparam logic [31:0] TV_B [9] = '{32'h40800000, 32'h40000000, 32'h40000000, 32'h40A00000, 32'h40E00000,
                                       32'h3F000000, 32'h40400000, 32'h40800000, 32'h00000001};
  localparam logic [31:0] TV_O [9] = '{32'h41400000, 32'h40800000, 32'h40400000, 32'hC0A00000, 32'h00000000,
                                       32'h3E800000, fp_pkg::INF, fp_pkg::QNAN | 32'h80000000, 32'h00000000};
  localparam logic [2:0] TV_F [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b001};

  function automatic logic [34:0] look(input logic [31:0] a, input logic [31:0] b);
    look = {3'b111, 32'hDEADBEEF};
    for (int i = 0; i < 9; i++) if (TV_A[i] == a && TV_B[i] == b) look = {TV_F[i], TV_O[i]};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;
  op_t lq [4][$];

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = lq[i].size() != 0;
      bus.req_a[i*32 +: 32] = lq[i].size() != 0 ? lq[i][0].a : 32'h0;
      bus.req_b[i*32 +: 32] = lq[i].size() != 0 ? lq[i][0].b : 32'h0;
    end
  endtask

  task automatic cycle();
    logic [3:0] acc;
    @(negedge clk);
    #1 acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) lq[i].delete(0);
    drive();
  endtask

  task automatic rsp(input string n, input int id, input logic [31:0] o, input logic [2:0] f);
    chk({n, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({n, "_id"}, 32'(bus.rsp_id), 32'(id));
    chk({n, "_out"}, bus.rsp_out, o);
    chk({n, "_flags"}, 32'({bus.rsp_invalid, bus.rsp_overflow, bus.rsp_underflow}), 32'(f));
  endtask

  // Model: one result slot, a wrap-around pointer and a table of known products
  initial begin
    bit m_valid, free;
    int m_ptr, m_id, g;
    logic [31:0] m_out;
    logic [2:0] m_fl, m_st;
    logic [34:0] r;
    logic [3:0] er;
    m_valid = 0; m_ptr = 0; m_id = 0; m_out = 0; m_fl = 0; m_st = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_out", bus.rsp_out, 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_flags", 32'({bus.rsp_invalid, bus.rsp_overflow, bus.rsp_underflow}), 32'd0);
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
`endif
        m_valid = 0; m_ptr = 0; m_id = 0; m_out = 0; m_fl = 0; m_st = 0;
      end else begin
        free = !m_valid || bus.rsp_ready;
        g = -1;
        if (free) for (int i = 0; i < 4; i++) if (g < 0 && bus.req_valid[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
        er = g >= 0 ? 4'(1 << g) : 4'b0;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
        if (m_valid) begin
          chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
          chk("rsp_out", bus.rsp_out, m_out);
          chk("rsp_flags", 32'({bus.rsp_invalid, bus.rsp_overflow, bus.rsp_underflow}), 32'(m_fl));
        end
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
        chk("sticky", 32'(sticky_flags), 32'(m_st));
`endif
        r = '0;
        if (g >= 0) begin
          r = look(bus.req_a[g*32 +: 32], bus.req_b[g*32 +: 32]);
          m_valid = 1; m_id = g; m_out = r[31:0]; m_fl = r[34:32]; m_ptr = (g + 1) % 4;
        end else if (bus.rsp_ready) m_valid = 0;
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
        m_st = sticky_clear ? 3'b000 : g >= 0 ? m_st | r[34:32] : m_st;
`endif
      end
    end
  end

  initial begin
    int ids [6];
    logic [31:0] outs [6];
    ids = '{0, 1, 2, 3, 0, 1};
    outs = '{32'h41400000, 32'h40800000, 32'hC0A00000, 32'h00000000, 32'h3E800000, 32'h40400000};
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
    sticky_clear = 1'b0;
`endif
    #1 rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    lq[0].push_back({32'h40400000, 32'h40800000});
    lq[0].push_back({32'h3F000000, 32'h3F000000});
    lq[1].push_back({32'h40000000, 32'h40000000});
    lq[1].push_back({32'h3FC00000, 32'h40000000});
    lq[2].push_back({32'hBF800000, 32'h40A00000});
    lq[3].push_back({32'h00000000, 32'h40E00000});
    drive();
    #1 chk("first_ready", 32'(bus.req_ready), 32'h1);
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk("seq_id", 32'(bus.rsp_id), 32'(ids[j]));
      chk("seq_out", bus.rsp_out, outs[j]);
    end
    cycle();
    chk("drain_valid", 32'(bus.rsp_valid), 32'd0);
    chk("drain_keep", bus.rsp_out, 32'h40400000);
    lq[2].push_back({32'h40400000, 32'h40800000});
    drive();
    cycle();
    rsp("single", 2, 32'h41400000, 3'b000);
    lq[0].push_back({32'h40000000, 32'h40000000});
    lq[1].push_back({32'h3FC00000, 32'h40000000});
    drive();
    cycle();
    bus.rsp_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycle();
      rsp("hold", 0, 32'h40800000, 3'b000);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("release_ready", 32'(bus.req_ready), 32'h2);
    cycle();
    rsp("release", 1, 32'h40400000, 3'b000);
    cycle();
    lq[1].push_back({32'h7F800000, 32'h40400000});
    lq[3].push_back({32'hFFA00000, 32'h40800000});
    lq[0].push_back({32'h00000001, 32'h00000001});
    drive();
    cycle();
    rsp("invalid", 3, 32'hFFC00000, 3'b100);
    cycle();
    rsp("underflow", 0, 32'h00000000, 3'b001);
    cycle();
    rsp("overflow", 1, 32'h7F800000, 3'b010);
`ifdef FP_MUL_ARB_STICKY_FLAGS_EN
    chk("sticky_all", 32'(sticky_flags), 32'h7);
    sticky_clear = 1'b1;
    cycle();
    sticky_clear = 1'b0;
    chk("sticky_clr", 32'(sticky_flags), 32'h0);
    lq[2].push_back({32'h7F800000, 32'h40400000});
    drive();
    cycle();
    lq[2].push_back({32'h00000001, 32'h00000001});
    drive();
    cycle();
    chk("sticky_ou", 32'(sticky_flags), 32'h3);
    lq[2].push_back({32'h7F800000, 32'h40400000});
    drive();
    sticky_clear = 1'b1;
    cycle();
    sticky_clear = 1'b0;
    chk("sticky_clr_wins", 32'(sticky_flags), 32'h0);
    chk("clr_rsp_of", 32'(bus.rsp_overflow), 32'd1);
`endif
    cycle();
    lq[2].push_back({32'h40000000, 32'h40000000});
    drive();
    cycle();
    bus.rsp_ready = 1'b0;
    lq[3].push_back({32'h3F000000, 32'h3F000000});
    lq[0].push_back({32'hBF800000, 32'h40A00000});
    drive();
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_rst_ready", 32'(bus.req_ready), 32'd0);
    cycle();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(bus.req_ready), 32'h1);
    cycle();
    rsp("post_rst0", 0, 32'hC0A00000, 3'b000);
    cycle();
    rsp("post_rst3", 3, 32'h3E800000, 3'b000);
    cycle();
    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
